// File: rtl/uart_frame_rx_if.sv
// Handshake bundle between a framed-message receiver and its byte source / frame consumer.
// master = producer/consumer side, slave = the decoder itself.
interface uart_frame_rx_if #(
  parameter int LEN_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frm_valid;
  logic [LEN_W-1:0] frm_len;
  logic             frm_ack;
  logic [LEN_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             frm_err;
  logic             busy;

  modport master (
    output rx_data, rx_valid, frm_ack, rd_idx,
    input  frm_valid, frm_len, rd_data, frm_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, frm_ack, rd_idx,
    output frm_valid, frm_len, rd_data, frm_err, busy
  );
endinterface

// File: rtl/uart_frame_rx.sv
// STX..ETX framed-message decoder: buffers the payload and holds it for indexed reads until acknowledged.
// Optional trailing XOR checksum byte enabled by defining UART_FRAME_RX_CKSUM_EN.
module uart_frame_rx #(
  parameter int         MAX_LEN = 16,
  parameter int         LEN_W   = 5,
  parameter logic [7:0] STX_CHR = 8'h02,
  parameter logic [7:0] ETX_CHR = 8'h03
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_frame_rx_if.slave  bus
);

  localparam int DEPTH = 1 << LEN_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_frm_valid;
  logic [LEN_W-1:0] r_frm_len;
  logic             r_frm_err;
  logic             r_busy;
  logic [7:0]       r_rd_data;
  logic [7:0]       r_buf [DEPTH];
`ifdef UART_FRAME_RX_CKSUM_EN
  logic [7:0]       r_xor;
`endif

  logic w_is_stx;
  logic w_is_etx;
  logic w_room;
  logic w_wr_en;

  assign w_is_stx = bus.rx_valid && (bus.rx_data == STX_CHR);
  assign w_is_etx = bus.rx_valid && (bus.rx_data == ETX_CHR);
  assign w_room   = r_len < LEN_W'(MAX_LEN);
  assign w_wr_en  = (r_state == S_COLLECT) && bus.rx_valid && !w_is_stx && !w_is_etx && w_room;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_frm_valid <= 1'b0;
      r_frm_len   <= '0;
      r_frm_err   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_FRAME_RX_CKSUM_EN
      r_xor       <= 8'h00;
`endif
    end else begin
      r_frm_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_stx) begin
            r_state <= S_COLLECT;
            r_len   <= '0;
            r_busy  <= 1'b1;
`ifdef UART_FRAME_RX_CKSUM_EN
            r_xor   <= 8'h00;
`endif
          end
        end
        S_COLLECT: begin
          if (w_is_stx) begin
            r_len <= '0;
`ifdef UART_FRAME_RX_CKSUM_EN
            r_xor <= 8'h00;
`endif
          end else if (w_is_etx) begin
`ifdef UART_FRAME_RX_CKSUM_EN
            // XOR over payload plus checksum byte is zero exactly when the checksum matches.
            if ((r_len == '0) || (r_xor != 8'h00)) begin
              r_frm_err <= 1'b1;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_state     <= S_DONE;
              r_frm_valid <= 1'b1;
              r_frm_len   <= r_len - LEN_W'(1);
            end
`else
            r_state     <= S_DONE;
            r_frm_valid <= 1'b1;
            r_frm_len   <= r_len;
`endif
          end else if (bus.rx_valid) begin
            if (w_room) begin
              r_len <= r_len + LEN_W'(1);
`ifdef UART_FRAME_RX_CKSUM_EN
              r_xor <= r_xor ^ bus.rx_data;
`endif
            end else begin
              r_frm_err <= 1'b1;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.frm_ack) begin
            r_state     <= S_IDLE;
            r_frm_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage keeps its contents across reset; only the read port is cleared.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_buf[r_len] <= bus.rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= (r_frm_valid && (bus.rd_idx < r_frm_len)) ? r_buf[bus.rd_idx] : 8'h00;
    end
  end

  assign bus.frm_valid = r_frm_valid;
  assign bus.frm_len   = r_frm_len;
  assign bus.frm_err   = r_frm_err;
  assign bus.busy      = r_busy;
  assign bus.rd_data   = r_rd_data;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Table-driven bench for uart_frame_rx: one record per clock cycle with inputs and expected outputs.
// Define UART_FRAME_RX_CKSUM_EN to exercise the checksum build instead of the plain build.
module tb_uart_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_frame_rx_if #(.LEN_W(5)) bus ();

  uart_frame_rx #(
    .MAX_LEN(16),
    .LEN_W  (5),
    .STX_CHR(8'h02),
    .ETX_CHR(8'h03)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       a;
    logic [4:0] idx;
    logic       e_valid;
    logic [4:0] e_len;
    logic       e_err;
    logic       e_busy;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string tag, input logic r, input logic v, input logic [7:0] d,
                              input logic a, input logic [4:0] idx, input logic ev,
                              input logic [4:0] el, input logic ee, input logic eb,
                              input logic [7:0] er);
    vec_t t;
    t.tag = tag; t.rst = r; t.v = v; t.d = d; t.a = a; t.idx = idx;
    t.e_valid = ev; t.e_len = el; t.e_err = ee; t.e_busy = eb; t.e_rd = er;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] t1d [6];
  logic [7:0] t6d [7];

  initial begin
    t1d[0] = 8'h41; t1d[1] = 8'h52; t1d[2] = 8'h54;
    t1d[3] = 8'h59; t1d[4] = 8'h0D; t1d[5] = 8'h0A;
    t6d[0] = 8'h41; t6d[1] = 8'h52; t6d[2] = 8'h54; t6d[3] = 8'h59;
    t6d[4] = 8'h0D; t6d[5] = 8'h0A; t6d[6] = 8'h19;

`ifndef UART_FRAME_RX_CKSUM_EN
    // T1: six-byte frame, read back every index plus one past the end
    add("t1", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) add("t1", 0, 1, t1d[i], 0, 0, 0, 0, 0, 1, 8'h00);
    add("t1", 0, 1, 8'h03, 0, 0, 1, 5'd6, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) add("t1rd", 0, 0, 8'h00, 0, 5'(i), 1, 5'd6, 0, 1, t1d[i]);
    add("t1rd", 0, 0, 8'h00, 0, 5'd6, 1, 5'd6, 0, 1, 8'h00);
    add("t1ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h41);
    add("t1idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    // T2: junk ignored, then one-byte frame; ACK while collecting is ignored
    add("t2", 0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t2", 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t2", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t2", 0, 1, 8'h41, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t2ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h00);
    add("t2", 0, 1, 8'h03, 0, 0, 1, 5'd1, 0, 1, 8'h00);
    add("t2rd", 0, 0, 8'h00, 0, 5'd0, 1, 5'd1, 0, 1, 8'h41);
    add("t2rd", 0, 0, 8'h00, 0, 5'd1, 1, 5'd1, 0, 1, 8'h00);
    add("t2ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h41);
    add("t2idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    // T3: 17 payload bytes overflow; 16 bytes then ETX is accepted
    add("t3", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) add("t3", 0, 1, 8'h5A, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t3ovf", 0, 1, 8'h5A, 0, 0, 0, 0, 1, 0, 8'h00);
    add("t3post", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t3b", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) add("t3b", 0, 1, 8'h5A, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t3b", 0, 1, 8'h03, 0, 0, 1, 5'd16, 0, 1, 8'h00);
    add("t3rd", 0, 0, 8'h00, 0, 5'd15, 1, 5'd16, 0, 1, 8'h5A);
    add("t3rd", 0, 0, 8'h00, 0, 5'd16, 1, 5'd16, 0, 1, 8'h00);
    add("t3ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h5A);
    add("t3idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    // T4: STX restart, bytes in DONE dropped, ACK wins over a simultaneous STX
    add("t4", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t4", 0, 1, 8'h41, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t4", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t4", 0, 1, 8'h42, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t4", 0, 1, 8'h03, 0, 0, 1, 5'd1, 0, 1, 8'h00);
    add("t4rd", 0, 0, 8'h00, 0, 0, 1, 5'd1, 0, 1, 8'h42);
    add("t4drop", 0, 1, 8'h02, 0, 0, 1, 5'd1, 0, 1, 8'h42);
    add("t4drop", 0, 1, 8'h43, 0, 0, 1, 5'd1, 0, 1, 8'h42);
    add("t4drop", 0, 1, 8'h03, 0, 0, 1, 5'd1, 0, 1, 8'h42);
    add("t4rd", 0, 0, 8'h00, 0, 0, 1, 5'd1, 0, 1, 8'h42);
    add("t4ack", 0, 1, 8'h02, 1, 0, 0, 0, 0, 0, 8'h42);
    add("t4idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    // T5: reset mid-frame drops it silently
    add("t5", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t5", 0, 1, 8'h41, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t5rst", 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t5", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t5", 0, 1, 8'h44, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t5", 0, 1, 8'h03, 0, 0, 1, 5'd1, 0, 1, 8'h00);
    add("t5rd", 0, 0, 8'h00, 0, 0, 1, 5'd1, 0, 1, 8'h44);
    add("t5ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h44);
    add("t5idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
`else
    // T6: good checksum, bad checksum, empty frame
    add("t6", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 7; i++) add("t6", 0, 1, t6d[i], 0, 0, 0, 0, 0, 1, 8'h00);
    add("t6", 0, 1, 8'h03, 0, 0, 1, 5'd6, 0, 1, 8'h00);
    add("t6rd", 0, 0, 8'h00, 0, 5'd5, 1, 5'd6, 0, 1, 8'h0A);
    add("t6rd", 0, 0, 8'h00, 0, 5'd6, 1, 5'd6, 0, 1, 8'h00);
    add("t6ack", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h41);
    add("t6idle", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t6bad", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) add("t6bad", 0, 1, t6d[i], 0, 0, 0, 0, 0, 1, 8'h00);
    add("t6bad", 0, 1, 8'h18, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t6bad", 0, 1, 8'h03, 0, 0, 0, 0, 1, 0, 8'h00);
    add("t6post", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add("t6emp", 0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 8'h00);
    add("t6emp", 0, 1, 8'h03, 0, 0, 0, 0, 1, 0, 8'h00);
    add("t6post", 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
`endif

    // Hand-written reset sequence: all outputs cleared
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.frm_ack  = 1'b0;
    bus.rd_idx   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(bus.frm_valid), 32'd0);
    chk("reset.len",   32'(bus.frm_len),   32'd0);
    chk("reset.err",   32'(bus.frm_err),   32'd0);
    chk("reset.busy",  32'(bus.busy),      32'd0);
    chk("reset.rd",    32'(bus.rd_data),   32'd0);
    $display("vec reset: checked outputs after reset");

    for (int i = 0; i < vq.size(); i++) begin
      rst          = vq[i].rst;
      bus.rx_valid = vq[i].v;
      bus.rx_data  = vq[i].d;
      bus.frm_ack  = vq[i].a;
      bus.rd_idx   = vq[i].idx;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].valid", vq[i].tag, i), 32'(bus.frm_valid), 32'(vq[i].e_valid));
      if (vq[i].e_valid)
        chk($sformatf("%s[%0d].len", vq[i].tag, i), 32'(bus.frm_len), 32'(vq[i].e_len));
      chk($sformatf("%s[%0d].err", vq[i].tag, i), 32'(bus.frm_err), 32'(vq[i].e_err));
      chk($sformatf("%s[%0d].busy", vq[i].tag, i), 32'(bus.busy), 32'(vq[i].e_busy));
      chk($sformatf("%s[%0d].rd", vq[i].tag, i), 32'(bus.rd_data), 32'(vq[i].e_rd));
      $display("vec %0d %s: rst=%0d v=%0d d=%02h ack=%0d idx=%0d -> valid=%0d len=%0d err=%0d busy=%0d rd=%02h",
               i, vq[i].tag, vq[i].rst, vq[i].v, vq[i].d, vq[i].a, vq[i].idx,
               bus.frm_valid, bus.frm_len, bus.frm_err, bus.busy, bus.rd_data);
    end

    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.frm_ack  = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
